medicine_uart_rx: RTL and testbench

MEDICINE_UART_RX -- requirements
Module: medicine_uart_rx

---
 rtl/medicine_uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_medicine_uart_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/medicine_uart_rx.sv
// 8N1 serial receiver for the medicine controller link: 16x oversampled bit
// recovery feeding a 4-entry first-word-fall-through FIFO.
module medicine_uart_rx #(
    parameter int DIV = 27
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxd,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam logic [11:0] TICK_MAX = 12'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        rxd_p0;
    logic        rxd_p1;
    logic        rxs;

    logic [11:0] tick_cnt;
    logic        tick;
    logic [3:0]  os_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;

    logic        push;
    logic        ferr_set;

    logic [7:0]  mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        full;
    logic        pop;
    logic        drop;
    logic        wr_en;

    // synchronizer stage boundary: rxd is asynchronous to clk
    always_ff @(posedge clk) begin
        if (n_rst) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
        end
    end

    assign rxs  = rxd_p1;
    assign tick = (state != IDLE) && (tick_cnt == TICK_MAX);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (tick && os_cnt == 4'd7) begin
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && os_cnt == 4'd15 && bit_cnt == 3'd7) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick && os_cnt == 4'd15) begin
                    state_nxt = IDLE;
                    push      = rxs;
                    ferr_set  = !rxs;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Oversample counter restarts at the start-bit midpoint so every later
    // sample lands 16 ticks later, i.e. in the middle of each bit cell.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
        end else begin
            tick_cnt <= tick ? 12'd0 : tick_cnt + 12'd1;
            if (tick) begin
                if (state == START && os_cnt == 4'd7) begin
                    os_cnt <= '0;
                end else begin
                    os_cnt <= os_cnt + 4'd1;
                end
                if (state == DATA && os_cnt == 4'd15) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && tick && os_cnt == 4'd15) begin
            shift_reg <= {rxs, shift_reg[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_set;
        end
    end

    // FIFO stage boundary: a pop frees the head slot in the same cycle, so a
    // push into a full FIFO alongside a pop is accepted.
    assign rd_valid = (count != 3'd0);
    assign full     = (count == 3'd4);
    assign pop      = rd_en && rd_valid;
    assign drop     = push && full && !pop;
    assign wr_en    = push && !drop;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= shift_reg;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_medicine_uart_rx.sv
// Directed bench for medicine_uart_rx at DIV=1 (16 clocks per serial bit).
module tb_medicine_uart_rx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rxd;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    medicine_uart_rx #(.DIV(1)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rxd      (rxd),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .frame_err(frame_err),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [6];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_fall = 0;

    int   ferr_hi     = 0;
    int   ferr_rise   = 0;
    logic ferr_q      = 1'b0;
    logic rv_q        = 1'b0;
    int   rv_rise_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_hi++;
        if (frame_err === 1'b1 && ferr_q === 1'b0) ferr_rise++;
        ferr_q = frame_err;
        if (rd_valid === 1'b1 && rv_q === 1'b0) rv_rise_cyc = cyc;
        rv_q = rd_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_lat(input string name);
        int lat;
        lat = rv_rise_cyc - t_fall;
        total++;
        if (lat < 152 || lat > 156) begin
            bad++;
            $display("FAIL %s: latency %0d expected 152..156", name, lat);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd    = 1'b0;
        t_fall = cyc;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            step(16);
        end
        rxd = stop;
        step(16);
        rxd = 1'b1;
    endtask

    initial begin
        int   base_hi;
        int   base_rise;
        logic saw_busy;

        vecs[0] = '{8'h35, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b1};

        rxd   = 1'b1;
        rd_en = 1'b0;
        n_rst = 1'b1;
        step(3);
        chk("reset rd_valid",  32'(rd_valid),  32'd0);
        chk("reset rd_data",   32'(rd_data),   32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset overflow",  32'(overflow),  32'd0);
        chk("reset busy",      32'(busy),      32'd0);
        n_rst = 1'b0;
        step(5);

        foreach (vecs[k]) begin
            base_hi   = ferr_hi;
            base_rise = ferr_rise;
            send_frame(vecs[k].data, vecs[k].stop);
            step(10);
            chk($sformatf("vec%0d rd_valid", k), 32'(rd_valid), 32'(vecs[k].exp_push));
            if (vecs[k].exp_push) begin
                chk($sformatf("vec%0d rd_data", k), 32'(rd_data), 32'(vecs[k].data));
                chk_lat($sformatf("vec%0d latency", k));
            end
            chk($sformatf("vec%0d ferr cycles", k), 32'(ferr_hi - base_hi), 32'(vecs[k].exp_ferr));
            chk($sformatf("vec%0d ferr pulses", k), 32'(ferr_rise - base_rise), 32'(vecs[k].exp_ferr));
            chk($sformatf("vec%0d busy", k), 32'(busy), 32'd0);
            if (vecs[k].exp_push) begin
                rd_en = 1'b1;
                step(2);
                rd_en = 1'b0;
                chk($sformatf("vec%0d rd_valid after pop", k), 32'(rd_valid), 32'd0);
            end
        end

        // start-bit glitch shorter than half a bit
        base_hi  = ferr_hi;
        saw_busy = 1'b0;
        rxd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        rxd = 1'b1;
        step(8);
        chk("glitch busy seen", 32'(saw_busy), 32'd1);
        chk("glitch busy at midpoint", 32'(busy), 32'd0);
        step(20);
        chk("glitch rd_valid", 32'(rd_valid), 32'd0);
        chk("glitch frame_err", 32'(ferr_hi - base_hi), 32'd0);

        // five back-to-back frames into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 4) chk("overflow before 5th", 32'(overflow), 32'd0);
        end
        step(2);
        chk("overflow after 5th", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf pop%0d rd_valid", i), 32'(rd_valid), 32'd1);
            chk($sformatf("ovf pop%0d rd_data", i), 32'(rd_data), 32'(i + 1));
            rd_en = 1'b1;
            step(1);
            rd_en = 1'b0;
        end
        chk("ovf drained rd_valid", 32'(rd_valid), 32'd0);
        chk("overflow sticky", 32'(overflow), 32'd1);

        // reset in the middle of the 4th data bit of a frame
        base_hi = ferr_hi;
        rxd = 1'b0;
        step(16);
        for (int i = 0; i < 3; i++) begin
            rxd = (i == 1) ? 1'b1 : 1'b0;
            step(16);
        end
        rxd = 1'b1;
        step(8);
        chk("pre-reset busy", 32'(busy), 32'd1);
        n_rst = 1'b1;
        step(3);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset overflow", 32'(overflow), 32'd0);
        n_rst = 1'b0;
        step(120);
        chk("after abort rd_valid", 32'(rd_valid), 32'd0);
        chk("after abort frame_err", 32'(ferr_hi - base_hi), 32'd0);
        send_frame(8'h7E, 1'b1);
        step(10);
        chk("post-reset rd_valid", 32'(rd_valid), 32'd1);
        chk("post-reset rd_data", 32'(rd_data), 32'h7E);
        chk("post-reset overflow", 32'(overflow), 32'd0);
        chk_lat("post-reset latency");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
